// File: rtl/isu_exu_skid.sv
// isu_exu_skid: two-entry in-order skid buffer between issue and execute with flush kill and kill counter
module isu_exu_skid #(
  parameter int DATA_WIDTH = 248,
  parameter int ID_WIDTH   = 7
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_payload,
  input  logic [63:0]           in_src1,
  input  logic [63:0]           in_src2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_payload,
  output logic [63:0]           out_src1,
  output logic [63:0]           out_src2,
  input  logic                  flush_valid,
  input  logic [ID_WIDTH-1:0]   flush_id,
  output logic [1:0]            occupancy,
  output logic [15:0]           kill_count
);
  localparam int EW = DATA_WIDTH + 128;

  logic          h_v, t_v, nh_v, nt_v;
  logic [EW-1:0] h_d, t_d, nh_d, nt_d, in_d;
  logic          kill_h, kill_t, kill_in, push, pop, acc, hs, ts;
  logic [1:0]    kills;
  logic [16:0]   kc_sum;
  logic [15:0]   nkc;

  function automatic logic younger(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] f);
    return (a[ID_WIDTH-1] == f[ID_WIDTH-1]) ? (a[ID_WIDTH-2:0] > f[ID_WIDTH-2:0])
                                            : (a[ID_WIDTH-2:0] < f[ID_WIDTH-2:0]);
  endfunction

  assign in_d        = {in_payload, in_src1, in_src2};
  assign out_payload = h_d[EW-1 -: DATA_WIDTH];
  assign out_src1    = h_d[127:64];
  assign out_src2    = h_d[63:0];
  assign occupancy   = {1'b0, h_v} + {1'b0, t_v};
  assign in_ready    = !(h_v && t_v);

  // kill decisions, handshakes and compaction of survivors plus accepted input
  always_comb begin
    kill_h    = h_v && flush_valid && younger(h_d[EW-1 -: ID_WIDTH], flush_id);
    kill_t    = t_v && flush_valid && younger(t_d[EW-1 -: ID_WIDTH], flush_id);
    push      = in_valid && in_ready;
    kill_in   = push && flush_valid && younger(in_payload[DATA_WIDTH-1 -: ID_WIDTH], flush_id);
    acc       = push && !kill_in;
    out_valid = h_v && !kill_h;
    pop       = out_valid && out_ready;
    hs        = h_v && !kill_h && !pop;
    ts        = t_v && !kill_t;
    nh_v      = hs || ts || acc;
    nh_d      = hs ? h_d : ts ? t_d : acc ? in_d : h_d;
    nt_v      = (hs && ts) || ((hs || ts) && acc);
    nt_d      = (hs && ts) ? t_d : ((hs || ts) && acc) ? in_d : t_d;
    kills     = {1'b0, kill_h} + {1'b0, kill_t} + {1'b0, kill_in};
    kc_sum    = {1'b0, kill_count} + 17'(kills);
    nkc       = kc_sum[16] ? 16'hFFFF : kc_sum[15:0];
  end

  // entry state and saturating kill counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_v        <= 1'b0;
      t_v        <= 1'b0;
      h_d        <= '0;
      t_d        <= '0;
      kill_count <= '0;
    end else begin
      h_v        <= nh_v;
      t_v        <= nt_v;
      h_d        <= nh_d;
      t_d        <= nt_d;
      kill_count <= nkc;
    end
  end
endmodule

// File: tb/tb_isu_exu_skid.sv
// tb_isu_exu_skid: directed and random scoreboard bench for isu_exu_skid
module tb_isu_exu_skid;
  typedef struct {
    logic [247:0] p;
    logic [63:0]  a;
    logic [63:0]  b;
  } ent_t;

  logic         clock, reset_n, in_valid, in_ready, out_valid, out_ready, flush_valid;
  logic [247:0] in_payload, out_payload;
  logic [63:0]  in_src1, in_src2, out_src1, out_src2;
  logic [6:0]   flush_id;
  logic [1:0]   occupancy;
  logic [15:0]  kill_count;

  ent_t q[$];
  int   kc, total, bad;

  isu_exu_skid dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .in_src1(in_src1), .in_src2(in_src2),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_src1(out_src1), .out_src2(out_src2), .flush_valid(flush_valid),
    .flush_id(flush_id), .occupancy(occupancy), .kill_count(kill_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic yng(input logic [6:0] a, input logic [6:0] f);
    return (a[6] == f[6]) ? (a[5:0] > f[5:0]) : (a[5:0] < f[5:0]);
  endfunction

  function automatic logic [247:0] mk(input logic [6:0] id);
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return {id, r[240:0]};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic iv, input logic [6:0] id, input logic [63:0] s1, input logic [63:0] s2,
                     input logic ordy, input logic fv, input logic [6:0] fid);
    ent_t e;
    ent_t nq[$];
    logic eov, pop, push;
    int   k;
    @(negedge clock);
    e.p = mk(id); e.a = s1; e.b = s2;
    in_valid = iv; in_payload = e.p; in_src1 = s1; in_src2 = s2;
    out_ready = ordy; flush_valid = fv; flush_id = fid;
    #1;
    eov = q.size() > 0 && !(fv && yng(q[0].p[247:241], fid));
    chk("in_ready", in_ready, q.size() != 2);
    chk("occupancy", occupancy, q.size());
    chk("out_valid", out_valid, eov);
    if (eov) begin
      chk("out_payload", out_payload, q[0].p);
      chk("out_src1", out_src1, q[0].a);
      chk("out_src2", out_src2, q[0].b);
    end
    pop = eov && ordy;
    push = iv && q.size() < 2;
    k = 0;
    foreach (q[i]) begin
      if (fv && yng(q[i].p[247:241], fid)) k++;
      else if (!(i == 0 && pop)) nq.push_back(q[i]);
    end
    if (push) begin
      if (fv && yng(id, fid)) k++;
      else nq.push_back(e);
    end
    q = nq;
    kc = (kc + k > 65535) ? 65535 : kc + k;
    @(posedge clock);
    #1;
    chk("kill_count", kill_count, kc);
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 7'h00, 64'h0, 64'h0, ordy, 1'b0, 7'h00);
  endtask

  initial begin
    total = 0; bad = 0; kc = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_payload = '0; in_src1 = '0; in_src2 = '0;
    out_ready = 1'b0; flush_valid = 1'b0; flush_id = '0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_kill_count", kill_count, 16'd0);
    chk("rst_out_payload", out_payload, 248'd0);
    @(negedge clock);
    reset_n = 1'b1;

    cyc(1'b1, 7'h05, 64'h11, 64'h21, 1'b0, 1'b0, 7'h00);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    cyc(1'b1, 7'h05, 64'h15, 64'h25, 1'b0, 1'b0, 7'h00);
    cyc(1'b1, 7'h06, 64'h16, 64'h26, 1'b0, 1'b0, 7'h00);
    cyc(1'b1, 7'h07, 64'h17, 64'h27, 1'b0, 1'b0, 7'h00);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    cyc(1'b1, 7'h05, 64'h35, 64'h45, 1'b0, 1'b0, 7'h00);
    cyc(1'b1, 7'h06, 64'h36, 64'h46, 1'b0, 1'b0, 7'h00);
    cyc(1'b0, 7'h00, 64'h0, 64'h0, 1'b0, 1'b1, 7'h05);
    idle(1'b0);
    idle(1'b1);

    cyc(1'b1, 7'h3E, 64'h3E, 64'h3E, 1'b0, 1'b0, 7'h00);
    cyc(1'b1, 7'h41, 64'h41, 64'h41, 1'b0, 1'b0, 7'h00);
    cyc(1'b0, 7'h00, 64'h0, 64'h0, 1'b0, 1'b1, 7'h3F);
    idle(1'b0);
    idle(1'b1);

    cyc(1'b1, 7'h05, 64'h55, 64'h65, 1'b0, 1'b0, 7'h00);
    cyc(1'b1, 7'h06, 64'h56, 64'h66, 1'b0, 1'b0, 7'h00);
    cyc(1'b1, 7'h07, 64'h57, 64'h67, 1'b1, 1'b1, 7'h04);
    cyc(1'b1, 7'h07, 64'h57, 64'h67, 1'b1, 1'b1, 7'h04);
    idle(1'b0);

    cyc(1'b1, 7'h08, 64'h88, 64'h98, 1'b0, 1'b0, 7'h00);
    cyc(1'b1, 7'h09, 64'h89, 64'h99, 1'b1, 1'b0, 7'h00);
    idle(1'b0);
    idle(1'b1);

    for (int i = 0; i < 80; i++)
      cyc(1'($urandom), 7'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
          1'($urandom), ($urandom % 4) == 0, 7'($urandom));
    for (int i = 0; i < 4; i++) idle(1'b1);

    for (int i = 0; i < 65540; i++)
      cyc(1'b1, 7'h10, 64'h0, 64'h0, 1'b0, 1'b1, 7'h05);
    chk("kill_saturated", kill_count, 16'hFFFF);

    cyc(1'b1, 7'h05, 64'hA5, 64'hB5, 1'b0, 1'b0, 7'h00);
    cyc(1'b1, 7'h06, 64'hA6, 64'hB6, 1'b0, 1'b0, 7'h00);
    @(negedge clock);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_occupancy", occupancy, 2'd0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_kill_count", kill_count, 16'd0);
    q.delete();
    kc = 0;
    #1;
    reset_n = 1'b1;
    cyc(1'b1, 7'h09, 64'hC9, 64'hD9, 1'b0, 1'b0, 7'h00);
    idle(1'b1);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
